// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states,
// opcodes, immediate/ALU codes and datapath mux selects.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_JALR_J,
    S_LUI
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // FSM request to the ALU decoder: fixed add, fixed sub, or decode funct fields
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_RESULT = 1'b1;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMM       = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decoder: maps the FSM's alu_op request plus funct fields
// onto the 3-bit ALU control code.
module alu_decoder
  import riscv_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  logic [1:0]            alu_op,
  input  logic [2:0]            funct3,
  input  logic                  funct7_5,
  input  logic                  op5,
  output logic [ALU_CTRL_W-1:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALU_OP_SUB: alu_control = ALU_SUB;
      ALU_OP_FUNCT: begin
        case (funct3)
          // op5 separates R-type from OP-IMM so addi never subtracts
          3'b000:  alu_control = (op5 && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b100:  alu_control = ALU_XOR;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          3'b010:  alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core (Moore state decode plus ALU decoder).
// Define MEM_WAIT_EN to add the mem_ready handshake on FETCH/MEM_READ/MEM_WRITE.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 3,
  parameter int IMM_SEL_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7_5,
  input  logic                  zero,
  input  logic                  neg,
`ifdef MEM_WAIT_EN
  input  logic                  mem_ready,
`endif
  output logic                  pc_write,
  output logic                  adr_src,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  reg_write,
  output logic [1:0]            result_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [IMM_SEL_W-1:0]  imm_src
);

  state_e     state_q, state_d;
  logic       mem_rdy;
  logic       pc_w, adr_s, mem_w, ir_w, reg_w;
  logic [1:0] res_s, src_a, src_b, alu_op;
  logic [2:0] imm_s;

`ifdef MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pc_w    = 1'b0;
    adr_s   = ADR_PC;
    mem_w   = 1'b0;
    ir_w    = 1'b0;
    reg_w   = 1'b0;
    res_s   = RES_ALUOUT;
    src_a   = SRCA_PC;
    src_b   = SRCB_RS2;
    alu_op  = ALU_OP_ADD;
    imm_s   = IMM_I;
    case (state_q)
      S_FETCH: begin
        src_b = SRCB_FOUR;
        res_s = RES_ALURESULT;
        if (mem_rdy) begin
          ir_w    = 1'b1;
          pc_w    = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        src_a = SRCA_OLDPC;
        src_b = SRCB_IMM;
        if (op == OP_BRANCH)   imm_s = IMM_B;
        else if (op == OP_JAL) imm_s = IMM_J;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
          OP_R:              state_d = S_EXEC_R;
          OP_IMM:            state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEM_ADR: begin
        src_a   = SRCA_RS1;
        src_b   = SRCB_IMM;
        imm_s   = (op == OP_STORE) ? IMM_S : IMM_I;
        state_d = (op == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        adr_s = ADR_RESULT;
        if (mem_rdy) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        res_s   = RES_DATA;
        reg_w   = 1'b1;
        state_d = S_FETCH;
      end
      S_MEM_WRITE: begin
        adr_s = ADR_RESULT;
        if (mem_rdy) begin
          mem_w   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC_R: begin
        src_a   = SRCA_RS1;
        alu_op  = ALU_OP_FUNCT;
        state_d = S_ALU_WB;
      end
      S_EXEC_I: begin
        src_a   = SRCA_RS1;
        src_b   = SRCB_IMM;
        alu_op  = ALU_OP_FUNCT;
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_w   = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        src_a  = SRCA_RS1;
        alu_op = ALU_OP_SUB;
        case (funct3)
          3'b000:  pc_w = zero;
          3'b001:  pc_w = ~zero;
          3'b100:  pc_w = neg;
          3'b101:  pc_w = ~neg;
          default: pc_w = 1'b0;
        endcase
        state_d = S_FETCH;
      end
      S_JAL, S_JALR_J: begin
        // PC <= ALUOut (target) while the ALU forms oldPC+4 for the link write
        src_a   = SRCA_OLDPC;
        src_b   = SRCB_FOUR;
        pc_w    = 1'b1;
        state_d = S_ALU_WB;
      end
      S_JALR: begin
        src_a   = SRCA_RS1;
        src_b   = SRCB_IMM;
        state_d = S_JALR_J;
      end
      S_LUI: begin
        imm_s   = IMM_U;
        res_s   = RES_IMM;
        reg_w   = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset overrides the FETCH decode so strobes and selects are quiet while rst is high
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    imm_src    = '0;
    if (!rst) begin
      pc_write   = pc_w;
      adr_src    = adr_s;
      mem_write  = mem_w;
      ir_write   = ir_w;
      reg_write  = reg_w;
      result_src = res_s;
      alu_src_a  = src_a;
      alu_src_b  = src_b;
      imm_src    = imm_s;
    end
  end

  alu_decoder #(
    .ALU_CTRL_W (ALU_CTRL_W)
  ) u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .op5         (op[5]),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// through its state sequence and checks the decoded control outputs.
module tb_multicycle_controller;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       neg;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control, imm_src;

  int passed = 0;
  int total  = 0;

  multicycle_controller dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .zero        (zero),
    .neg         (neg),
`ifdef MEM_WAIT_EN
    .mem_ready   (mem_ready),
`endif
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .imm_src     (imm_src)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobes packed as {pc_write, mem_write, ir_write, reg_write}
  function automatic logic [3:0] strobes();
    return {pc_write, mem_write, ir_write, reg_write};
  endfunction

  initial begin
    rst = 1'b1; op = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0;
    zero = 1'b0; neg = 1'b0; mem_ready = 1'b1;
    #1;
    chk("rst_strobes", strobes(), 4'b0000);
    chk("rst_src_b", alu_src_b, 2'b00);
    chk("rst_result_src", result_src, 2'b00);
    tick(); tick();
    rst = 1'b0; #1;
    chk("fetch_strobes", strobes(), 4'b1010);
    chk("fetch_src_b", alu_src_b, 2'b10);
    chk("fetch_result_src", result_src, 2'b10);
    chk("fetch_adr_src", adr_src, 1'b0);

    // lw
    op = 7'b0000011; funct3 = 3'b010;
    tick(); chk("lw_dec_src_a", alu_src_a, 2'b01); chk("lw_dec_src_b", alu_src_b, 2'b01);
    chk("lw_dec_strobes", strobes(), 4'b0000);
    tick(); chk("lw_adr_imm", imm_src, 3'd0); chk("lw_adr_src_a", alu_src_a, 2'b10);
    chk("lw_adr_alu", alu_control, 3'b000);
    tick(); chk("lw_rd_adr", adr_src, 1'b1); chk("lw_rd_strobes", strobes(), 4'b0000);
    tick(); chk("lw_wb_strobes", strobes(), 4'b0001); chk("lw_wb_res", result_src, 2'b01);
    tick(); chk("lw_done_fetch", strobes(), 4'b1010);

    // sw, then reset while in MEM_WRITE
    op = 7'b0100011;
    tick(); chk("sw_dec_imm", imm_src, 3'd0);
    tick(); chk("sw_adr_imm", imm_src, 3'd1);
    tick(); chk("sw_wr_strobes", strobes(), 4'b0100); chk("sw_wr_adr", adr_src, 1'b1);
    #1 rst = 1'b1; #1;
    chk("rst_mid_sw_strobes", strobes(), 4'b0000);
    chk("rst_mid_sw_adr", adr_src, 1'b0);
    tick();
    rst = 1'b0; #1;
    chk("post_rst_fetch", strobes(), 4'b1010);

    // R-type sub
    op = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b1;
    tick();
    tick(); chk("sub_alu", alu_control, 3'b001); chk("sub_src_a", alu_src_a, 2'b10);
    chk("sub_src_b", alu_src_b, 2'b00);
    funct3 = 3'b111; #1; chk("and_alu", alu_control, 3'b010);
    funct3 = 3'b110; #1; chk("or_alu", alu_control, 3'b011);
    funct3 = 3'b001; #1; chk("r_other_alu", alu_control, 3'b000);
    tick(); chk("r_wb_strobes", strobes(), 4'b0001); chk("r_wb_res", result_src, 2'b00);
    tick(); chk("r_done_fetch", strobes(), 4'b1010);

    // addi with funct7_5=1 must not subtract
    op = 7'b0010011; funct3 = 3'b000; funct7_5 = 1'b1;
    tick();
    tick(); chk("addi_alu", alu_control, 3'b000); chk("addi_src_b", alu_src_b, 2'b01);
    chk("addi_imm", imm_src, 3'd0);
    funct3 = 3'b100; #1; chk("xori_alu", alu_control, 3'b100);
    funct3 = 3'b010; #1; chk("slti_alu", alu_control, 3'b101);
    tick(); chk("i_wb_strobes", strobes(), 4'b0001);
    tick(); funct7_5 = 1'b0;

    // beq
    op = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
    tick(); chk("beq_dec_imm", imm_src, 3'd2);
    tick(); chk("beq_taken", pc_write, 1'b1); chk("beq_alu", alu_control, 3'b001);
    chk("beq_res", result_src, 2'b00);
    zero = 1'b0; #1; chk("beq_not_taken", pc_write, 1'b0);
    tick(); chk("beq_done_fetch", strobes(), 4'b1010);

    // bge / bne
    funct3 = 3'b101; neg = 1'b0;
    tick();
    tick(); chk("bge_taken", pc_write, 1'b1);
    neg = 1'b1; #1; chk("bge_not_taken", pc_write, 1'b0);
    funct3 = 3'b001; zero = 1'b0; #1; chk("bne_taken", pc_write, 1'b1);
    funct3 = 3'b010; #1; chk("bad_funct3_branch", pc_write, 1'b0);
    tick(); neg = 1'b0;

    // jal
    op = 7'b1101111;
    tick(); chk("jal_dec_imm", imm_src, 3'd4);
    tick(); chk("jal_strobes", strobes(), 4'b1000); chk("jal_src_a", alu_src_a, 2'b01);
    chk("jal_src_b", alu_src_b, 2'b10);
    tick(); chk("jal_wb_strobes", strobes(), 4'b0001);
    tick(); chk("jal_done_fetch", strobes(), 4'b1010);

    // jalr
    op = 7'b1100111;
    tick();
    tick(); chk("jalr_strobes", strobes(), 4'b0000); chk("jalr_src_a", alu_src_a, 2'b10);
    chk("jalr_src_b", alu_src_b, 2'b01);
    tick(); chk("jalrj_strobes", strobes(), 4'b1000); chk("jalrj_src_a", alu_src_a, 2'b01);
    tick(); chk("jalr_wb_strobes", strobes(), 4'b0001);
    tick(); chk("jalr_done_fetch", strobes(), 4'b1010);

    // lui
    op = 7'b0110111;
    tick();
    tick(); chk("lui_imm", imm_src, 3'd3); chk("lui_res", result_src, 2'b11);
    chk("lui_strobes", strobes(), 4'b0001);
    tick(); chk("lui_done_fetch", strobes(), 4'b1010);

    // illegal opcode
    op = 7'b1111111;
    tick(); chk("illegal_dec_strobes", strobes(), 4'b0000);
    tick(); chk("illegal_back_fetch", strobes(), 4'b1010);

`ifdef MEM_WAIT_EN
    mem_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("wait_fetch_hold", strobes(), 4'b0000);
      chk("wait_fetch_src_b", alu_src_b, 2'b10);
      tick();
    end
    mem_ready = 1'b1; #1;
    chk("wait_fetch_ready", strobes(), 4'b1010);
    op = 7'b0000011;
    tick(); chk("wait_decode", alu_src_a, 2'b01);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
